// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: latches EX results and control for the MEM stage,
// with stall (hold), flush (bubble) and the EX/MEM forwarding-valid flag.
module ex_mem_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_AW-1:0] write_reg,
   input  logic [DATA_W-1:0] branch_target,
   input  logic              reg_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   input  logic              branch,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [DATA_W-1:0] mem_branch_target,
   output logic [REG_AW-1:0] mem_write_reg,
   output logic              mem_reg_write,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic              mem_to_reg_o,
   output logic              pc_src,
   output logic              fwd_valid
);

   logic              r_valid;
   logic [DATA_W-1:0] r_alu_result;
   logic [DATA_W-1:0] r_store_data;
   logic [DATA_W-1:0] r_branch_target;
   logic [REG_AW-1:0] r_write_reg;
   logic              r_reg_write;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_mem_to_reg;
   logic              r_pc_src;

   logic              w_reg_write;
   logic              w_mem_read;
   logic              w_mem_write;
   logic              w_mem_to_reg;
   logic              w_pc_src;

   // A read+write request is illegal; degrade it to a plain read.
   always_comb begin
      w_reg_write  = ex_valid & reg_write & (write_reg != '0);
      w_mem_read   = ex_valid & mem_read;
      w_mem_write  = ex_valid & mem_write & ~mem_read;
      w_mem_to_reg = ex_valid & mem_to_reg;
      w_pc_src     = ex_valid & branch & alu_zero;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid         <= 1'b0;
         r_alu_result    <= '0;
         r_store_data    <= '0;
         r_branch_target <= '0;
         r_write_reg     <= '0;
         r_reg_write     <= 1'b0;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_to_reg    <= 1'b0;
         r_pc_src        <= 1'b0;
      end else if (flush) begin
         // Bubble: kill control only, data registers keep their contents.
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_pc_src     <= 1'b0;
      end else if (!stall) begin
         r_valid         <= ex_valid;
         r_alu_result    <= alu_result;
         r_store_data    <= store_data;
         r_branch_target <= branch_target;
         r_write_reg     <= write_reg;
         r_reg_write     <= w_reg_write;
         r_mem_read      <= w_mem_read;
         r_mem_write     <= w_mem_write;
         r_mem_to_reg    <= w_mem_to_reg;
         r_pc_src        <= w_pc_src;
      end
   end

   assign mem_valid         = r_valid;
   assign mem_alu_result    = r_alu_result;
   assign mem_store_data    = r_store_data;
   assign mem_branch_target = r_branch_target;
   assign mem_write_reg     = r_write_reg;
   assign mem_reg_write     = r_reg_write;
   assign mem_read_en       = r_mem_read;
   assign mem_write_en      = r_mem_write;
   assign mem_to_reg_o      = r_mem_to_reg;
   assign pc_src            = r_pc_src;
   assign fwd_valid         = r_valid & r_reg_write & (r_write_reg != '0);

endmodule
